seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Sequences the shared single-digit 7-segment decoder across a 4-digit common-anode display for the whack-a-mole score/timer readout.
- Accepts a binary value on a load strobe and converts it to BCD with a serial double-dabble engine, one bit per cycle.
- Time-multiplexes the BCD digits onto the decoder's 4-bit num input with one-hot active-low digit selects.
- Leading-zero blanking is optional.

Parameters:
- NUM_DIGITS, 4, number of display digits; the BCD width is 4*NUM_DIGITS. Only the value 4 is supported.
- VAL_W, 14, width of the binary input value.
- SCAN_DIV, 50000, clk cycles each digit stays selected. Must be >= 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- load  input  1  single-cycle strobe that starts a conversion of value
- value  input  VAL_W  binary value to display, unsigned
- blank_lz  input  1  1 = suppress leading zeros; digit 0 is never blanked
- busy  output  1  conversion in progress
- num  output  4  BCD digit driven to the decoder's num input, always 0..9
- dig_sel_n  output  NUM_DIGITS  active-low digit enable; bit i selects digit i, bit 0 = units

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - busy=0, num=0, dig_sel_n=all 1s.
  - Displayed BCD register=0, scratch registers=0.
  - Scan index=0, divider=0, conversion FSM=IDLE.
- Reset asserted mid-conversion aborts the conversion. The displayed BCD register returns to 0.
- Conversion FSM, states IDLE, SHIFT, DONE:
  - IDLE: load=1 captures min(value, 9999) into the shift register and clears the BCD scratch. Iteration counter is set to 0. Next state is SHIFT and busy=1 from the next cycle.
  - SHIFT: one double-dabble iteration per cycle. Each scratch nibble >= 5 gets +3, then {scratch, shift} shifts left 1. After VAL_W iterations the next state is DONE.
  - DONE: the scratch is copied to the displayed BCD register in one cycle, atomically. Next state is IDLE; busy=0 from the next cycle.
  - Timing: load sampled at edge E0 gives busy high after E0, display update at edge E(VAL_W+1), and busy low after it. busy is high for exactly VAL_W+1 cycles.
  - load while busy=1 is ignored, with no queuing. load in the same cycle that DONE completes is also ignored.
  - The displayed value never shows a partial conversion.
- Scan:
  - The divider counts 0..SCAN_DIV-1 and wraps.
  - On the wrap cycle the scan index increments mod NUM_DIGITS (3 wraps to 0).
- Outputs num and dig_sel_n are registered from the scan index and the displayed BCD register, one cycle latency.
  - The first edge after reset release drives digit 0: dig_sel_n=4'b1110 and num=units digit.
- Digit select: dig_sel_n has exactly one 0 per slot, or all 1s for a blanked slot.
- Leading-zero blanking: a slot is blanked when all of the following hold:
  - blank_lz=1
  - index i != 0
  - digit i and every higher digit are 0
  - A blanked slot drives num=0 and dig_sel_n=all 1s. Scan timing is unchanged.
- blank_lz is sampled every cycle and takes effect on the next registered output.
- A display update mid-slot takes effect on the next cycle, within the current slot.
- Values >= 10000 saturate to 9999.

Test Plan:
- Reset, then idle with SCAN_DIV=4:
  - dig_sel_n cycles 1110, 1101, 1011, 0111, each held 4 cycles, then repeats.
  - num=0 throughout; busy=0.
- load with value=1234, blank_lz=0:
  - busy high 15 cycles.
  - Afterwards num=4, 3, 2, 1 on dig_sel_n=1110, 1101, 1011, 0111 respectively.
- value=7, blank_lz=1:
  - Slot 0 shows num=7, dig_sel_n=1110.
  - Slots 1–3 drive dig_sel_n=1111, num=0.
  - Slots keep 4-cycle spacing.
- value=0, blank_lz=1: only digit 0 is enabled, showing num=0.
- value=16383: display saturates to 9999 (num=9 on every digit).
- Load conflicts and reset:
  - load value=56, then load value=99 on cycle 5 of busy: display 0056; the second load is ignored.
  - rst_n low during SHIFT: busy=0 and display 0 immediately.

Source files
------------

// File: rtl/seg_scan_if.sv
// Handshake bundle between the score/timer logic and the digit scan controller.
// The master side drives load/value/blank_lz; the controller returns busy and the decoder drive.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 4,
  parameter int VAL_W      = 14
);
  logic                  load;
  logic [VAL_W-1:0]      value;
  logic                  blank_lz;
  logic                  busy;
  logic [3:0]            num;
  logic [NUM_DIGITS-1:0] dig_sel_n;

  modport master (output load, value, blank_lz, input busy, num, dig_sel_n);
  modport slave  (input load, value, blank_lz, output busy, num, dig_sel_n);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Serial binary-to-BCD conversion plus time-multiplexed drive of a shared 7-segment decoder
// across a common-anode display, with optional leading-zero blanking.
module seg_scan_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int VAL_W      = 14,
   parameter int SCAN_DIV   = 50000
) (
   input logic     clk,
   input logic     rst_n,
   seg_scan_if.slave bus
);

   localparam int BCD_W  = 4 * NUM_DIGITS;
   localparam int IDX_W  = $clog2(NUM_DIGITS);
   localparam int DIV_W  = $clog2(SCAN_DIV);
   localparam int ITER_W = $clog2(VAL_W);

   localparam logic [VAL_W-1:0]  SAT_MAX   = VAL_W'(9999);
   localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(VAL_W - 1);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

   conv_state_t           state;
   logic [VAL_W-1:0]      shift_q;
   logic [BCD_W-1:0]      scratch_q;
   logic [BCD_W-1:0]      adj;
   logic [ITER_W-1:0]     iter_q;
   logic [BCD_W-1:0]      disp_q;
   logic                  busy_q;

   logic [DIV_W-1:0]      div_q;
   logic [IDX_W-1:0]      idx_q;
   logic [3:0]            num_q;
   logic [NUM_DIGITS-1:0] sel_q;
   logic [NUM_DIGITS-1:0] blank_mask;
   logic                  all_zero;
   logic [3:0]            cur_digit;
   logic                  blank_now;

   // NOTE: every variable gets a value before any conditional update so no latch is inferred.
   always_comb begin
      adj = scratch_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         shift_q   <= '0;
         scratch_q <= '0;
         iter_q    <= '0;
         disp_q    <= '0;
         busy_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.load) begin
                  shift_q   <= (bus.value > SAT_MAX) ? SAT_MAX : bus.value;
                  scratch_q <= '0;
                  iter_q    <= '0;
                  busy_q    <= 1'b1;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               scratch_q <= {adj[BCD_W-2:0], shift_q[VAL_W-1]};
               shift_q   <= {shift_q[VAL_W-2:0], 1'b0};
               iter_q    <= iter_q + 1'b1;
               if (iter_q == ITER_LAST) state <= DONE;
            end
            DONE: begin
               // Only this single copy touches the shown value, so no partial result is ever displayed.
               disp_q <= scratch_q;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A slot is blank-eligible when its digit and every higher digit are zero; digit 0 never is.
   always_comb begin
      blank_mask = '0;
      all_zero   = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         all_zero      = all_zero && (disp_q[4*i +: 4] == 4'd0);
         blank_mask[i] = all_zero;
      end
   end

   assign cur_digit = disp_q[{idx_q, 2'b00} +: 4];
   assign blank_now = bus.blank_lz && blank_mask[idx_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
         idx_q <= '0;
         num_q <= '0;
         sel_q <= '1;
      end else begin
         if (div_q == DIV_LAST) begin
            div_q <= '0;
            idx_q <= idx_q + 1'b1;
         end else begin
            div_q <= div_q + 1'b1;
         end
         num_q <= blank_now ? 4'd0 : cur_digit;
         sel_q <= blank_now ? '1 : ~(NUM_DIGITS'(1) << idx_q);
      end
   end

   assign bus.busy      = busy_q;
   assign bus.num       = num_q;
   assign bus.dig_sel_n = sel_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a short scan period so whole rotations fit in a few cycles.
module tb_seg_scan_ctrl;

   localparam int SCAN_DIV = 4;

   logic clk;
   logic rst_n;
   int   total;
   int   passed;
   int   edges;

   seg_scan_if #(.NUM_DIGITS(4), .VAL_W(14)) bus ();

   seg_scan_ctrl #(.NUM_DIGITS(4), .VAL_W(14), .SCAN_DIV(SCAN_DIV)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Posedges since reset release; the scan slot shown after edge k is ((k-1)/SCAN_DIV)%4.
   always @(posedge clk) begin
      if (!rst_n) edges = 0;
      else        edges = edges + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Advance one cycle and compare the decoder drive against the expected display contents.
   task automatic step_check(input logic [15:0] bcd, input logic blank, input string tag);
      int         slot;
      logic       hi_zero;
      logic       blanked;
      logic [3:0] exp_num;
      logic [3:0] exp_sel;
      @(negedge clk);
      slot    = ((edges - 1) / SCAN_DIV) % 4;
      hi_zero = 1'b1;
      for (int j = slot; j < 4; j++) hi_zero = hi_zero && (bcd[4*j +: 4] == 4'd0);
      blanked = blank && (slot != 0) && hi_zero;
      exp_num = blanked ? 4'd0 : bcd[4*slot +: 4];
      exp_sel = blanked ? 4'b1111 : ~(4'b0001 << slot);
      check({tag, "_sel"}, 32'(bus.dig_sel_n), 32'(exp_sel));
      check({tag, "_num"}, 32'(bus.num), 32'(exp_num));
   endtask

   task automatic check_scan(input logic [15:0] bcd, input logic blank, input string tag, input int n);
      for (int k = 0; k < n; k++) step_check(bcd, blank, tag);
   endtask

   // Issue one load; optionally fire a second load on a given busy cycle. Ends on the negedge after busy falls.
   task automatic do_load(input logic [13:0] v, input int conf_cycle, input logic [13:0] conf_v,
                          input string tag);
      int cnt;
      @(negedge clk);
      bus.load  = 1'b1;
      bus.value = v;
      @(negedge clk);
      bus.load  = 1'b0;
      cnt = 0;
      while (bus.busy === 1'b1 && cnt < 40) begin
         cnt++;
         if (cnt == conf_cycle) begin
            bus.load  = 1'b1;
            bus.value = conf_v;
         end
         @(negedge clk);
         bus.load = 1'b0;
      end
      check({tag, "_busy_cycles"}, 32'(cnt), 32'd15);
   endtask

   initial begin
      total        = 0;
      passed       = 0;
      edges        = 0;
      rst_n        = 1'b0;
      bus.load     = 1'b0;
      bus.value    = '0;
      bus.blank_lz = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_sel",  32'(bus.dig_sel_n), 32'hF);
      check("rst_num",  32'(bus.num), 32'd0);
      rst_n = 1'b1;

      check_scan(16'h0000, 1'b0, "idle", 20);
      check("idle_busy", 32'(bus.busy), 32'd0);

      do_load(14'd1234, 0, 14'd0, "v1234");
      check_scan(16'h1234, 1'b0, "v1234", 16);

      bus.blank_lz = 1'b1;
      do_load(14'd7, 0, 14'd0, "v7");
      check_scan(16'h0007, 1'b1, "v7_blank", 16);

      do_load(14'd0, 0, 14'd0, "v0");
      check_scan(16'h0000, 1'b1, "v0_blank", 16);

      bus.blank_lz = 1'b0;
      do_load(14'd16383, 0, 14'd0, "vsat");
      check_scan(16'h9999, 1'b0, "vsat", 16);

      do_load(14'd56, 5, 14'd99, "v56_conflict");
      check_scan(16'h0056, 1'b0, "v56", 16);
      repeat (3) @(negedge clk);
      check("v56_no_queued_load", 32'(bus.busy), 32'd0);

      @(negedge clk);
      bus.load  = 1'b1;
      bus.value = 14'd1234;
      @(negedge clk);
      bus.load  = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_shift_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_sel",  32'(bus.dig_sel_n), 32'hF);
      check("abort_num",  32'(bus.num), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check_scan(16'h0000, 1'b0, "after_abort", 16);
      check("after_abort_busy", 32'(bus.busy), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
